// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side handshake bundle for fifo_wr_arbiter: per-requester valid/last/data
// driven by producers, per-requester ready returned by the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_LEN = 8
);
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_last;
    logic [NUM_REQ*DATA_LEN-1:0] req_data;
    logic [NUM_REQ-1:0]          req_ready;

    modport master (output req_valid, output req_last, output req_data, input req_ready);
    modport slave  (input req_valid, input req_last, input req_data, output req_ready);
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port, with local occupancy credit.
// Optional macro FIFO_ARB_PRIO0_EN: requester 0 takes absolute priority in IDLE.
//
// state | meaning
// IDLE  | no owner; choose a winner when any requester is valid and credit remains
// XFER  | grant_id owns the write port until last beat or MAX_BURST beats
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_LEN   = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  sys_rst_n,
    fifo_wr_arbiter_if.slave      req,
    output logic                  fifo_wr_en,
    output logic [DATA_LEN-1:0]   fifo_data_in,
    input  logic                  fifo_rd_en,
    input  logic                  fifo_empty,
    output logic [2:0]            grant_id,
    output logic                  busy,
    output logic [ADDR_WIDTH:0]   occupancy
);
    localparam int                  BW      = $clog2(MAX_BURST + 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [2:0]          LAST_ID = 3'(NUM_REQ - 1);
    localparam logic [BW-1:0]       BEAT_LAST_C = BW'(MAX_BURST - 1);

    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

    state_t                      state, state_next;
    logic [2:0]                  rr_ptr;
    logic [BW-1:0]               beat_cnt;
    logic                        prio_grant;
    logic [2:0]                  win_id;
    logic                        win_found;
    logic                        win_prio;
    logic [3:0]                  cand;
    logic [NUM_REQ-1:0]          vshift;
    logic [NUM_REQ-1:0]          gshift_v;
    logic [NUM_REQ-1:0]          gshift_l;
    logic [NUM_REQ*DATA_LEN-1:0] dshift;
    logic                        sel_valid;
    logic                        sel_last;
    logic [DATA_LEN-1:0]         sel_data;
    logic                        credit_ok;
    logic                        xfer;
    logic                        burst_end;
    logic                        rd_ok;

    // Upward search from rr_ptr with wrap; the first valid requester wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = rr_ptr;
        win_prio  = 1'b0;
        cand      = '0;
        vshift    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr} + 4'(i);
            if (cand >= 4'(NUM_REQ))
                cand = cand - 4'(NUM_REQ);
            vshift = req.req_valid >> cand;
            if (!win_found && vshift[0]) begin
                win_found = 1'b1;
                win_id    = cand[2:0];
            end
        end
`ifdef FIFO_ARB_PRIO0_EN
        // A priority win only counts when round-robin alone would not have picked 0.
        if (req.req_valid[0] && win_id != 3'd0) begin
            win_found = 1'b1;
            win_id    = 3'd0;
            win_prio  = 1'b1;
        end
`endif
    end

    always_comb begin
        gshift_v  = req.req_valid >> grant_id;
        gshift_l  = req.req_last >> grant_id;
        dshift    = req.req_data >> (int'(grant_id) * DATA_LEN);
        sel_valid = gshift_v[0];
        sel_last  = gshift_l[0];
        sel_data  = dshift[DATA_LEN-1:0];
    end

    assign credit_ok = (occupancy < DEPTH_C);
    assign xfer      = (state == XFER) && sel_valid && credit_ok;
    assign burst_end = xfer && (sel_last || (beat_cnt == BEAT_LAST_C));
    assign rd_ok     = fifo_rd_en && !fifo_empty && (occupancy != '0);
    assign busy      = (state == XFER);
    assign req.req_ready = ((state == XFER) && credit_ok) ? (NUM_REQ'(1) << grant_id) : '0;

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (win_found && credit_ok) state_next = XFER;
            XFER:    if (burst_end)              state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            grant_id   <= '0;
            prio_grant <= 1'b0;
            rr_ptr     <= '0;
            beat_cnt   <= '0;
        end else begin
            if (state == IDLE && state_next == XFER) begin
                grant_id   <= win_id;
                prio_grant <= win_prio;
            end
            if (burst_end)
                beat_cnt <= '0;
            else if (xfer)
                beat_cnt <= beat_cnt + BW'(1);
            if (burst_end && !prio_grant)
                rr_ptr <= (grant_id == LAST_ID) ? 3'd0 : grant_id + 3'd1;
        end
    end

    // Credit is taken at accept time so the in-flight registered write is already reserved.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fifo_wr_en   <= 1'b0;
            fifo_data_in <= '0;
            occupancy    <= '0;
        end else begin
            fifo_wr_en <= xfer;
            if (xfer)
                fifo_data_in <= sel_data;
            case ({xfer, rd_ok})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end
endmodule
